// File: rtl/pc_sequencer_if.sv
// Decoder/harness-facing bundle of the PC sequencer: control strobes, branch LUT
// handshake and status outputs.
interface pc_sequencer_if #(
   parameter int PC_W  = 10,
   parameter int PTR_W = 5,
   parameter int OFF_W = 8,
   parameter int CNT_W = 16
);
   logic             start;
   logic             stall;
   logic             halt_in;
   logic             br_req;
   logic             br_cond;
   logic [PTR_W-1:0] br_ptr;
   logic [OFF_W-1:0] lut_off;
   logic [PTR_W-1:0] lut_ptr;
   logic [PC_W-1:0]  pc;
   logic             running;
   logic             done;
   logic             timeout;
   logic             wrap_err;
   logic [CNT_W-1:0] cycle_cnt;

   modport master (
      output start, stall, halt_in, br_req, br_cond, br_ptr, lut_off,
      input  lut_ptr, pc, running, done, timeout, wrap_err, cycle_cnt
   );

   modport slave (
      input  start, stall, halt_in, br_req, br_cond, br_ptr, lut_off,
      output lut_ptr, pc, running, done, timeout, wrap_err, cycle_cnt
   );
endinterface

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: PC register, IDLE/RUN/DONE control, LUT-relative
// branches with wrap detection, and a saturating run-cycle counter with timeout.
module pc_sequencer #(
   parameter int PC_W       = 10,
   parameter int PTR_W      = 5,
   parameter int OFF_W      = 8,
   parameter int CNT_W      = 16,
   parameter int START_ADDR = 0
) (
   input logic            CLK,
   input logic            reset_n,
   pc_sequencer_if.slave  bus
);
   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   localparam logic [PC_W-1:0] START_PC = PC_W'(START_ADDR);

   logic [1:0]              state;
   logic [PC_W-1:0]         pc_r;
   logic [CNT_W-1:0]        cnt_r;
   logic                    timeout_r;
   logic                    wrap_r;
   logic signed [PC_W+1:0]  off_ext;
   logic signed [PC_W+1:0]  br_sum;
   logic                    br_wrap;

   // Two guard bits: bit PC_W+1 flags a negative sum, bit PC_W a sum past the top.
   always_comb begin
      off_ext = (PC_W+2)'($signed(bus.lut_off));
      br_sum  = $signed({2'b00, pc_r}) + off_ext;
      br_wrap = br_sum[PC_W+1] | br_sum[PC_W];
   end

   always_ff @(posedge CLK or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         pc_r      <= START_PC;
         cnt_r     <= '0;
         timeout_r <= 1'b0;
         wrap_r    <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (bus.start) begin
                  state     <= RUN;
                  pc_r      <= START_PC;
                  cnt_r     <= '0;
                  timeout_r <= 1'b0;
                  wrap_r    <= 1'b0;
               end
            end
            RUN: begin
               if (&cnt_r) begin
                  state     <= DONE;
                  timeout_r <= 1'b1;
               end else begin
                  cnt_r <= cnt_r + CNT_W'(1);
                  if (bus.stall) begin
                     pc_r <= pc_r;
                  end else if (bus.halt_in) begin
                     state <= DONE;
                  end else if (bus.br_req && bus.br_cond) begin
                     pc_r <= br_sum[PC_W-1:0];
                     if (br_wrap) wrap_r <= 1'b1;
                  end else begin
                     pc_r <= pc_r + PC_W'(1);
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.lut_ptr   = bus.br_ptr;
   assign bus.pc        = pc_r;
   assign bus.running   = (state == RUN);
   assign bus.done      = (state == DONE);
   assign bus.timeout   = timeout_r;
   assign bus.wrap_err  = wrap_r;
   assign bus.cycle_cnt = cnt_r;
endmodule
